// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access controller: owns MAR/MDR, sequences external memory
// handshakes and serves the keyboard/display device registers locally.
module lc3_mem_ctrl #(
  parameter logic [15:0] ADDR_KBSR = 16'hFE00,
  parameter logic [15:0] ADDR_KBDR = 16'hFE02,
  parameter logic [15:0] ADDR_DSR  = 16'hFE04,
  parameter logic [15:0] ADDR_DDR  = 16'hFE06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] busIn,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic        memEN,
  input  logic        memWE,
  output logic        R,
  output logic [15:0] marOut,
  output logic [15:0] mdrOut,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        disp_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Slot order matters: 0 = KBSR, 1 = KBDR, 2 = DSR, 3 = DDR.
  localparam logic [3:0][15:0] DEV_ADDR = {ADDR_DDR, ADDR_DSR, ADDR_KBDR, ADDR_KBSR};

  state_t      state_reg, state_next;
  logic [15:0] mar_reg, mar_next;
  logic [15:0] mdr_reg, mdr_next;
  logic        we_reg, we_next;
  logic        kb_full_reg, kb_full_next;
  logic [7:0]  kb_data_reg, kb_data_next;
  logic [7:0]  disp_data_reg, disp_data_next;
  logic        disp_valid_reg, disp_valid_next;
  logic [3:0]  dev_hit;
  logic [15:0] dev_rdata;
  logic        is_dev;
  logic        start;
  logic        kbdr_read;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign dev_hit[gi] = (mar_reg == DEV_ADDR[gi]);
    end
  endgenerate

  assign is_dev    = |dev_hit;
  assign start     = (state_reg == IDLE) && memEN;
  assign kbdr_read = start && !memWE && dev_hit[1];

  always_comb begin
    dev_rdata = '0;
    if (dev_hit[0])      dev_rdata = {kb_full_reg, 15'b0};
    else if (dev_hit[1]) dev_rdata = {8'b0, kb_data_reg};
    else if (dev_hit[2]) dev_rdata = {disp_ready, 15'b0};
  end

  always_comb begin
    state_next = state_reg;
    R          = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: if (memEN) state_next = is_dev ? DONE : WAIT;
      WAIT: begin
        mem_req = 1'b1;
        mem_we  = we_reg;
        if (mem_ready) state_next = DONE;
      end
      DONE: begin
        R          = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mar_next        = mar_reg;
    mdr_next        = mdr_reg;
    we_next         = we_reg;
    disp_data_next  = disp_data_reg;
    disp_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ldMAR) mar_next = busIn;
        if (ldMDR) mdr_next = busIn;
        if (memEN) begin
          we_next = memWE;
          if (is_dev && !memWE) mdr_next = dev_rdata;
          // Display write uses the MDR value held before this edge.
          if (dev_hit[3] && memWE) begin
            disp_data_next  = mdr_reg[7:0];
            disp_valid_next = 1'b1;
          end
        end
      end
      WAIT: if (mem_ready && !we_reg) mdr_next = mem_rdata;
      default: ;
    endcase
  end

  // An arriving character into an empty buffer beats a same-cycle KBDR clear.
  always_comb begin
    kb_full_next = kb_full_reg;
    kb_data_next = kb_data_reg;
    if (kb_valid && !kb_full_reg) begin
      kb_full_next = 1'b1;
      kb_data_next = kb_data;
    end else if (kbdr_read) begin
      kb_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mar_reg        <= '0;
      mdr_reg        <= '0;
      we_reg         <= 1'b0;
      kb_full_reg    <= 1'b0;
      kb_data_reg    <= '0;
      disp_data_reg  <= '0;
      disp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mar_reg        <= mar_next;
      mdr_reg        <= mdr_next;
      we_reg         <= we_next;
      kb_full_reg    <= kb_full_next;
      kb_data_reg    <= kb_data_next;
      disp_data_reg  <= disp_data_next;
      disp_valid_reg <= disp_valid_next;
    end
  end

  assign marOut     = mar_reg;
  assign mem_addr   = mar_reg;
  assign mdrOut     = mdr_reg;
  assign mem_wdata  = mdr_reg;
  assign disp_valid = disp_valid_reg;
  assign disp_data  = disp_data_reg;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: directed vector table, reset-abort sequence and
// randomized accesses scored against a transaction-level model.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] busIn = '0;
  logic        ldMAR = 1'b0, ldMDR = 1'b0, memEN = 1'b0, memWE = 1'b0;
  logic        R;
  logic [15:0] marOut, mdrOut, mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        disp_ready = 1'b0;
  logic        disp_valid;
  logic [7:0]  disp_data;

  lc3_mem_ctrl dut (
    .clk(clk), .reset(reset), .busIn(busIn), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .memEN(memEN), .memWE(memWE), .R(R), .marOut(marOut), .mdrOut(mdrOut),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_ready(disp_ready), .disp_valid(disp_valid), .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wd;
    logic        we;
    int          waits;
    logic [15:0] rdata;
    logic [8:0]  kb_pre;   // {valid, char} strobed before the access
    logic [8:0]  kb_at;    // {valid, char} strobed on the memEN edge
    logic        dr;
    logic [15:0] exp_mdr;
    int          exp_lat;
    int          exp_req;
    int          exp_dv;
    logic [7:0]  exp_dd;
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail  = 0;
  int txn     = 0;

  function automatic vec_t mk(logic [15:0] addr, logic [15:0] wd, logic we, int waits,
                              logic [15:0] rdata, logic [8:0] kb_pre, logic [8:0] kb_at,
                              logic dr, logic [15:0] exp_mdr, int exp_lat, int exp_req,
                              int exp_dv, logic [7:0] exp_dd);
    vec_t v;
    v.addr = addr; v.wd = wd; v.we = we; v.waits = waits; v.rdata = rdata;
    v.kb_pre = kb_pre; v.kb_at = kb_at; v.dr = dr; v.exp_mdr = exp_mdr;
    v.exp_lat = exp_lat; v.exp_req = exp_req; v.exp_dv = exp_dv; v.exp_dd = exp_dd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Loads MAR/MDR, fires memEN, serves the memory side, and records what was seen.
  // During the busy cycles it hammers ldMAR/ldMDR with 16'hFFFF, which must be ignored.
  task automatic run_access(input vec_t v, output logic [15:0] o_mdr, output logic [15:0] o_mar,
                            output int o_lat, output int o_req, output int o_dv,
                            output logic [7:0] o_dd, output int o_bad);
    o_mdr = 'x; o_mar = 'x; o_lat = -1; o_req = 0; o_dv = 0; o_dd = '0; o_bad = 0;
    if (v.kb_pre[8]) begin
      kb_valid = 1'b1; kb_data = v.kb_pre[7:0];
      tick();
      kb_valid = 1'b0;
    end
    disp_ready = v.dr;
    busIn = v.addr; ldMAR = 1'b1;
    tick();
    ldMAR = 1'b0; busIn = v.wd; ldMDR = 1'b1;
    tick();
    ldMDR = 1'b0;
    memEN = 1'b1; memWE = v.we;
    kb_valid = v.kb_at[8]; kb_data = v.kb_at[7:0];
    tick();
    memEN = 1'b0; kb_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_req) begin
        o_req++;
        if (mem_addr !== v.addr || mem_we !== v.we || mem_wdata !== v.wd) o_bad++;
      end
      if (disp_valid) begin
        o_dv++;
        o_dd = disp_data;
      end
      if (R) begin
        o_lat = c; o_mdr = mdrOut; o_mar = marOut;
        break;
      end
      mem_ready = mem_req && (c == v.waits + 1);
      mem_rdata = mem_ready ? v.rdata : 16'($urandom);
      busIn = 16'hFFFF; ldMAR = 1'($urandom); ldMDR = 1'($urandom);
      tick();
      mem_ready = 1'b0; ldMAR = 1'b0; ldMDR = 1'b0;
    end
    tick();
  endtask

  task automatic check_access(input vec_t v, input string tag);
    logic [15:0] o_mdr, o_mar;
    logic [7:0]  o_dd;
    int o_lat, o_req, o_dv, o_bad;
    run_access(v, o_mdr, o_mar, o_lat, o_req, o_dv, o_dd, o_bad);
    txn++;
    $display("[TB] %s txn %0d addr=%h we=%0d waits=%0d mdr=%h lat=%0d req=%0d dv=%0d dd=%h",
             tag, txn, v.addr, v.we, v.waits, o_mdr, o_lat, o_req, o_dv, o_dd);
    chk($sformatf("%s_%0d_latency", tag, txn), o_lat, v.exp_lat);
    chk($sformatf("%s_%0d_mdr", tag, txn), {16'b0, o_mdr}, {16'b0, v.exp_mdr});
    chk($sformatf("%s_%0d_mar", tag, txn), {16'b0, o_mar}, {16'b0, v.addr});
    chk($sformatf("%s_%0d_req_cycles", tag, txn), o_req, v.exp_req);
    chk($sformatf("%s_%0d_bus_stable", tag, txn), o_bad, 0);
    chk($sformatf("%s_%0d_disp_valid", tag, txn), o_dv, v.exp_dv);
    if (v.exp_dv != 0) chk($sformatf("%s_%0d_disp_data", tag, txn), {24'b0, o_dd}, {24'b0, v.exp_dd});
  endtask

  // Transaction-level reference state for the random phase.
  logic       m_kb_full;
  logic [7:0] m_kb_reg;

  initial begin
    int r_seen;
    vec_t v;

    tbl.push_back(mk(16'h3000, 16'h0000, 0, 0, 16'hBEEF, 9'h000, 9'h000, 0, 16'hBEEF, 2, 1, 0, 8'h00));
    tbl.push_back(mk(16'h4000, 16'h1234, 1, 3, 16'h5555, 9'h000, 9'h000, 0, 16'h1234, 5, 4, 0, 8'h00));
    tbl.push_back(mk(16'hFE00, 16'h0000, 0, 0, 16'h0000, 9'h141, 9'h000, 0, 16'h8000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE02, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h000, 0, 16'h0041, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE00, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h000, 0, 16'h0000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE00, 16'h0000, 0, 0, 16'h0000, 9'h142, 9'h000, 0, 16'h8000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE02, 16'h0000, 0, 0, 16'h0000, 9'h143, 9'h000, 0, 16'h0042, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE04, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h000, 1, 16'h8000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE04, 16'hFFFF, 0, 0, 16'h0000, 9'h000, 9'h000, 0, 16'h0000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE06, 16'h0058, 1, 0, 16'h0000, 9'h000, 9'h000, 1, 16'h0058, 1, 0, 1, 8'h58));
    tbl.push_back(mk(16'hFE06, 16'h7777, 0, 0, 16'h0000, 9'h000, 9'h000, 0, 16'h0000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE02, 16'hABCD, 1, 0, 16'h0000, 9'h000, 9'h000, 0, 16'hABCD, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE02, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h155, 0, 16'h0042, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE00, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h000, 0, 16'h8000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE02, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h166, 0, 16'h0055, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE00, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h000, 0, 16'h0000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(16'hFE01, 16'h0000, 0, 1, 16'h1111, 9'h000, 9'h000, 0, 16'h1111, 3, 2, 0, 8'h00));
    tbl.push_back(mk(16'hFE06, 16'h00A5, 1, 0, 16'h0000, 9'h000, 9'h000, 0, 16'h00A5, 1, 0, 1, 8'hA5));

    tick(); tick();
    chk("reset_R", {31'b0, R}, 0);
    chk("reset_mem_req", {31'b0, mem_req}, 0);
    chk("reset_mem_we", {31'b0, mem_we}, 0);
    chk("reset_mar", {16'b0, marOut}, 0);
    chk("reset_mdr", {16'b0, mdrOut}, 0);
    chk("reset_disp_valid", {31'b0, disp_valid}, 0);
    chk("reset_disp_data", {24'b0, disp_data}, 0);
    reset = 1'b0;
    tick();

    foreach (tbl[i]) check_access(tbl[i], "vec");

    // Reset while the external access waits: request drops, nothing completes.
    busIn = 16'h5000; ldMAR = 1'b1; tick();
    ldMAR = 1'b0; busIn = 16'h0707; ldMDR = 1'b1; tick();
    ldMDR = 1'b0; memEN = 1'b1; memWE = 1'b0; tick();
    memEN = 1'b0;
    chk("abort_req_c1", {31'b0, mem_req}, 1);
    tick();
    chk("abort_req_c2", {31'b0, mem_req}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_req_c3", {31'b0, mem_req}, 0);
    chk("abort_R_c3", {31'b0, R}, 0);
    chk("abort_mar_c3", {16'b0, marOut}, 0);
    chk("abort_mdr_c3", {16'b0, mdrOut}, 0);
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ready = 1'b0;
    r_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (R || mem_req) r_seen++;
      tick();
    end
    chk("abort_late_ready_no_R", r_seen, 0);
    $display("[TB] abort sequence done, late-ready activity=%0d", r_seen);
    check_access(mk(16'hFE04, 16'h0000, 0, 0, 16'h0000, 9'h000, 9'h000, 1, 16'h8000, 1, 0, 0, 8'h00), "post_abort");

    // Reset leaves the keyboard empty; reference model starts from that.
    m_kb_full = 1'b0;
    m_kb_reg  = 8'h00;
    for (int n = 0; n < 60; n++) begin
      int sel;
      logic dev, is_kbdr_rd;
      v.we = 1'($urandom);
      sel = int'($urandom_range(0, 5));
      v.addr = (sel < 4) ? 16'hFE00 + 16'(2 * sel) : 16'($urandom);
      v.wd = 16'($urandom);
      v.waits = int'($urandom_range(0, 4));
      v.rdata = 16'($urandom);
      v.kb_pre = {1'($urandom), 8'($urandom)};
      v.kb_at  = ($urandom_range(0, 3) == 0) ? {1'b1, 8'($urandom)} : 9'h000;
      v.dr = 1'($urandom);

      if (v.kb_pre[8] && !m_kb_full) begin
        m_kb_full = 1'b1;
        m_kb_reg  = v.kb_pre[7:0];
      end
      dev = (v.addr == 16'hFE00) || (v.addr == 16'hFE02) || (v.addr == 16'hFE04) || (v.addr == 16'hFE06);
      v.exp_dv = 0;
      v.exp_dd = v.wd[7:0];
      if (dev) begin
        v.exp_lat = 1;
        v.exp_req = 0;
        if (v.we) begin
          v.exp_mdr = v.wd;
          if (v.addr == 16'hFE06) v.exp_dv = 1;
        end else begin
          case (v.addr)
            16'hFE00: v.exp_mdr = m_kb_full ? 16'h8000 : 16'h0000;
            16'hFE02: v.exp_mdr = {8'h00, m_kb_reg};
            16'hFE04: v.exp_mdr = v.dr ? 16'h8000 : 16'h0000;
            default:  v.exp_mdr = 16'h0000;
          endcase
        end
      end else begin
        v.exp_lat = v.waits + 2;
        v.exp_req = v.waits + 1;
        v.exp_mdr = v.we ? v.wd : v.rdata;
      end
      is_kbdr_rd = dev && !v.we && (v.addr == 16'hFE02);
      check_access(v, "rand");
      if (v.kb_at[8] && !m_kb_full) begin
        m_kb_full = 1'b1;
        m_kb_reg  = v.kb_at[7:0];
      end else if (is_kbdr_rd) begin
        m_kb_full = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
